// File: rtl/range_window_bank.sv
// range_window_bank: a bank of independent range windows that watch one shared up-count.
// Each channel arms on a runtime-loaded start count. It stays open for a loaded number of
// enabled ticks and then pulses done when it closes.
// Optional build macro: RANGE_WINDOW_ONESHOT_EN. When it is defined, a window that closes
// normally disarms the channel, and the channel needs a reload before it can fire again.
module range_window_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned LENGTH_WIDTH  = 8,
  localparam int unsigned CH_IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [COUNTER_WIDTH-1:0]         counter,
  input  logic                             enable,
  input  logic                             load,
  input  logic [CH_IDX_W-1:0]              load_channel,
  input  logic [COUNTER_WIDTH-1:0]         load_start,
  input  logic [LENGTH_WIDTH-1:0]          load_length,
  output logic [CHANNELS-1:0]              active,
  output logic [CHANNELS*LENGTH_WIDTH-1:0] elapsed,
  output logic [CHANNELS-1:0]              done,
  output logic                             any_active
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_OPEN     = 2'd2
  } state_t;

  state_t                   state_q   [CHANNELS];
  logic [COUNTER_WIDTH-1:0] start_q   [CHANNELS];
  logic [LENGTH_WIDTH-1:0]  length_q  [CHANNELS];
  logic [LENGTH_WIDTH-1:0]  elapsed_q [CHANNELS];

  // Per-channel window state machine; a load aborts the channel and takes priority over the tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]   <= ST_DISARMED;
        start_q[i]   <= '0;
        length_q[i]  <= '0;
        elapsed_q[i] <= '0;
        active[i]    <= 1'b0;
        done[i]      <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        done[i] <= 1'b0;
        if (load && (load_channel == CH_IDX_W'(i))) begin
          start_q[i]   <= load_start;
          length_q[i]  <= load_length;
          state_q[i]   <= (load_length != '0) ? ST_ARMED : ST_DISARMED;
          elapsed_q[i] <= '0;
          active[i]    <= 1'b0;
        end else if (enable) begin
          case (state_q[i])
            ST_ARMED: begin
              if (counter == start_q[i]) begin
                state_q[i]   <= ST_OPEN;
                active[i]    <= 1'b1;
                elapsed_q[i] <= '0;
              end
            end
            ST_OPEN: begin
              if (elapsed_q[i] == (length_q[i] - LENGTH_WIDTH'(1))) begin
                done[i]      <= 1'b1;
                elapsed_q[i] <= '0;
`ifdef RANGE_WINDOW_ONESHOT_EN
                state_q[i]   <= ST_DISARMED;
                active[i]    <= 1'b0;
`else
                // A match on the closing tick starts the next window with no gap.
                if (counter == start_q[i]) begin
                  state_q[i] <= ST_OPEN;
                  active[i]  <= 1'b1;
                end else begin
                  state_q[i] <= ST_ARMED;
                  active[i]  <= 1'b0;
                end
`endif
              end else begin
                elapsed_q[i] <= elapsed_q[i] + LENGTH_WIDTH'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Pack the per-channel elapsed counts onto the output bus.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_elapsed
    assign elapsed[g*LENGTH_WIDTH +: LENGTH_WIDTH] = elapsed_q[g];
  end

  // Summary flag taken straight from the registered active bits.
  assign any_active = |active;

endmodule
